// File: rtl/tone_div_sched_pkg.sv
// Shared types, constants and helpers for the time-multiplexed tone divider bank.
package tone_div_sched_pkg;

  localparam int DIV_OFF = 0;

  typedef enum logic {
    CFG_IDLE,
    CFG_PEND
  } cfg_state_e;

  function automatic int slot_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Full square-wave period in clocks for a given half-period divide value.
  function automatic longint tone_period(input longint div, input int nch);
    return 2 * div * nch;
  endfunction

  // Clocks from config apply to the first toggle.
  function automatic longint first_toggle(input longint div, input int nch);
    return div * nch;
  endfunction

endpackage

// File: rtl/tone_div_lane.sv
// Combinational next-state for the one channel serviced this cycle; shared by all
// channels through the slot mux.
module tone_div_lane
  import tone_div_sched_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic [CW-1:0] div,
  input  logic [CW-1:0] cnt,
  input  logic          tone,
  input  logic          apply,
  input  logic [CW-1:0] apply_div,
  output logic [CW-1:0] div_nxt,
  output logic [CW-1:0] cnt_nxt,
  output logic          tone_nxt,
  output logic          tick
);

  always_comb begin
    div_nxt  = div;
    cnt_nxt  = cnt;
    tone_nxt = tone;
    tick     = 1'b0;
    if (apply) begin
      // A fresh config restarts the channel low, silently, even if it was high.
      div_nxt  = apply_div;
      cnt_nxt  = '0;
      tone_nxt = 1'b0;
    end else if (div == CW'(DIV_OFF)) begin
      cnt_nxt  = '0;
      tone_nxt = 1'b0;
    end else if (cnt >= (div - CW'(1))) begin
      // >= rather than == so a counter left above the divide value recovers.
      cnt_nxt  = '0;
      tone_nxt = ~tone;
      tick     = 1'b1;
    end else begin
      cnt_nxt  = cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tone_div_sched.sv
// Round-robin programmable divider bank: one shared lane serves NCH channels, each
// retunable through a single-entry valid/ready config port.
module tone_div_sched
  import tone_div_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 16,
  localparam int SW = slot_width(NCH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [SW-1:0] cfg_ch,
  input  logic [CW-1:0] cfg_div,
  output logic [NCH-1:0] tone_out,
  output logic [NCH-1:0] tick_out,
  output logic [SW-1:0] slot
);

  logic [CW-1:0] div_r [NCH];
  logic [CW-1:0] cnt_r [NCH];

  cfg_state_e    state, state_nxt;
  logic [SW-1:0] pend_ch;
  logic [SW-1:0] pend_slot;
  logic [CW-1:0] pend_div;
  logic          accept;
  logic          apply;

  logic [SW-1:0] slot_nxt;
  logic [CW-1:0] lane_div_nxt;
  logic [CW-1:0] lane_cnt_nxt;
  logic          lane_tone_nxt;
  logic          lane_tick;
  logic [NCH-1:0] tick_vec;

  assign slot_nxt  = (slot == SW'(NCH - 1)) ? '0 : slot + SW'(1);
  assign cfg_ready = (state == CFG_IDLE);

  // Config handshake: one pending entry, released on apply or after a full slot
  // round (the latter drops channel indices that do not exist).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CFG_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    apply     = 1'b0;
    case (state)
      CFG_IDLE: begin
        if (cfg_valid) begin
          accept    = 1'b1;
          state_nxt = CFG_PEND;
        end
      end
      CFG_PEND: begin
        if (pend_ch == slot) begin
          apply     = 1'b1;
          state_nxt = CFG_IDLE;
        end else if (pend_slot == slot) begin
          state_nxt = CFG_IDLE;
        end
      end
      default: state_nxt = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_ch   <= '0;
      pend_slot <= '0;
      pend_div  <= '0;
    end else if (accept) begin
      pend_ch   <= cfg_ch;
      pend_slot <= slot;
      pend_div  <= cfg_div;
    end
  end

  tone_div_lane #(
    .CW(CW)
  ) u_lane (
    .div       (div_r[slot]),
    .cnt       (cnt_r[slot]),
    .tone      (tone_out[slot]),
    .apply     (apply),
    .apply_div (pend_div),
    .div_nxt   (lane_div_nxt),
    .cnt_nxt   (lane_cnt_nxt),
    .tone_nxt  (lane_tone_nxt),
    .tick      (lane_tick)
  );

  always_comb begin
    tick_vec       = '0;
    tick_vec[slot] = lane_tick;
  end

  // Slot pointer and per-channel state; only the serviced channel is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot     <= '0;
      tone_out <= '0;
      tick_out <= '0;
      for (int i = 0; i < NCH; i++) begin
        div_r[i] <= '0;
        cnt_r[i] <= '0;
      end
    end else begin
      slot           <= slot_nxt;
      tick_out       <= tick_vec;
      tone_out[slot] <= lane_tone_nxt;
      div_r[slot]    <= lane_div_nxt;
      cnt_r[slot]    <= lane_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_tone_div_sched.sv
// Directed bench for tone_div_sched: NCH=4/CW=16 main instance plus NCH=3/CW=8
// instance for the dropped-channel and full-range divide cases.
module tb_tone_div_sched;
  import tone_div_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_div = '0;
  logic [3:0]  tone_out;
  logic [3:0]  tick_out;
  logic [1:0]  slot;

  logic        cfg_valid3 = 1'b0;
  logic        cfg_ready3;
  logic [1:0]  cfg_ch3 = '0;
  logic [7:0]  cfg_div3 = '0;
  logic [2:0]  tone3;
  logic [2:0]  tick3;
  logic [1:0]  slot3;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  tone_div_sched #(.NCH(4), .CW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .tone_out  (tone_out),
    .tick_out  (tick_out),
    .slot      (slot)
  );

  tone_div_sched #(.NCH(3), .CW(8)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid3),
    .cfg_ready (cfg_ready3),
    .cfg_ch    (cfg_ch3),
    .cfg_div   (cfg_div3),
    .tone_out  (tone3),
    .tick_out  (tick3),
    .slot      (slot3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Present one config on the main instance in a cycle where slot==want; returns
  // the cycle count sampled just after the accepting edge.
  task automatic do_cfg(input int ch, input int dv, input int want, output int acc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(slot == 2'(want) && cfg_ready) && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check_eq("cfg_wait_timeout", 64'(guard >= 64), 64'd0);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = 16'(dv);
    @(negedge clk);
    cfg_valid = 1'b0;
    acc = cyc;
  endtask

  initial begin
    int c0, c1, g;
    logic acc;
    logic [3:0] acc4;
    logic [1:0] exp_slot [4];
    exp_slot[0] = 2'd1; exp_slot[1] = 2'd2; exp_slot[2] = 2'd3; exp_slot[3] = 2'd0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_eq("rst_tone", tone_out, 4'h0);
    check_eq("rst_tick", tick_out, 4'h0);
    check_eq("rst_ready", cfg_ready, 1'b1);
    check_eq("rst_slot", slot, 2'd0);
    check_eq("rst_ready3", cfg_ready3, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("slot_seq0", slot, 2'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("slot_seq", slot, exp_slot[i]);
    end

    // Basic divide: ch1 div=3, accepted in slot 0, applied next edge.
    do_cfg(1, 3, 0, c0);
    check_eq("basic_ready_low", cfg_ready, 1'b0);
    wait_cyc(c0 + 1);
    check_eq("basic_ready_back", cfg_ready, 1'b1);
    wait_cyc(c0 + 12);
    check_eq("basic_pre_tone", tone_out[1], 1'b0);
    check_eq("basic_pre_tick", tick_out[1], 1'b0);
    wait_cyc(c0 + 13);
    check_eq("basic_tog1_tone", tone_out[1], 1'b1);
    check_eq("basic_tog1_tick", tick_out[1], 1'b1);
    wait_cyc(c0 + 14);
    check_eq("basic_tick_1clk", tick_out[1], 1'b0);
    check_eq("basic_hold_tone", tone_out[1], 1'b1);
    wait_cyc(c0 + 25);
    check_eq("basic_tog2_tone", tone_out[1], 1'b0);
    check_eq("basic_tog2_tick", tick_out[1], 1'b1);
    wait_cyc(c0 + 13 + int'(tone_period(3, 4)));
    check_eq("basic_period", tone_out[1], 1'b1);

    // Handshake latency with cfg_valid held high across two transfers.
    @(negedge clk);
    g = 0;
    while (!(slot == 2'd2 && cfg_ready) && g < 64) begin
      @(negedge clk);
      g++;
    end
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd2;
    @(negedge clk);
    c0 = cyc;
    check_eq("hs_ready_low0", cfg_ready, 1'b0);
    cfg_ch = 2'd3; cfg_div = 16'd1;
    for (int k = 1; k < 4; k++) begin
      wait_cyc(c0 + k);
      check_eq("hs_ready_low", cfg_ready, 1'b0);
    end
    wait_cyc(c0 + 4);
    check_eq("hs_ready_back", cfg_ready, 1'b1);
    wait_cyc(c0 + 5);
    check_eq("hs_second_taken", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    wait_cyc(c0 + 9);
    check_eq("hs_second_applied", cfg_ready, 1'b1);
    wait_cyc(c0 + 11);
    check_eq("hs_ch2_pre", tone_out[2], 1'b0);
    wait_cyc(c0 + 12);
    check_eq("hs_ch2_tog", tone_out[2], 1'b1);
    check_eq("hs_ch2_tick", tick_out[2], 1'b1);
    wait_cyc(c0 + 13);
    check_eq("hs_ch3_tog", tone_out[3], 1'b1);
    check_eq("hs_ch3_tick", tick_out[3], 1'b1);

    // Retune ch0 while its tone is high.
    do_cfg(0, 5, 3, c0);
    wait_cyc(c0 + 20);
    check_eq("rt_pre_tone", tone_out[0], 1'b0);
    wait_cyc(c0 + 21);
    check_eq("rt_high", tone_out[0], 1'b1);
    do_cfg(0, 2, 3, c1);
    check_eq("rt_accept_cyc", 64'(c1 - c0), 64'd24);
    check_eq("rt_still_high", tone_out[0], 1'b1);
    wait_cyc(c1 + 1);
    check_eq("rt_apply_low", tone_out[0], 1'b0);
    check_eq("rt_apply_notick", tick_out[0], 1'b0);
    wait_cyc(c1 + 9);
    check_eq("rt_tog1", tone_out[0], 1'b1);
    check_eq("rt_tog1_tick", tick_out[0], 1'b1);
    wait_cyc(c1 + 17);
    check_eq("rt_tog2", tone_out[0], 1'b0);

    // Disable ch1 with div=0.
    do_cfg(1, 0, 0, c0);
    wait_cyc(c0 + 1);
    acc = 1'b0;
    repeat (40) begin
      acc = acc | tone_out[1] | tick_out[1];
      @(negedge clk);
    end
    check_eq("off_quiet", acc, 1'b0);

    // Reset while a config is pending.
    do_cfg(3, 7, 0, c0);
    check_eq("rp_pending", cfg_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("rp_ready", cfg_ready, 1'b1);
    check_eq("rp_slot", slot, 2'd0);
    check_eq("rp_tone", tone_out, 4'h0);
    check_eq("rp_tick", tick_out, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    acc4 = 4'h0;
    repeat (40) begin
      @(negedge clk);
      acc4 = acc4 | tone_out | tick_out;
    end
    check_eq("rp_all_quiet", acc4, 4'h0);
    check_eq("rp_ready_idle", cfg_ready, 1'b1);

    // NCH=3: nonexistent channel index is dropped.
    @(negedge clk);
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 8'd5;
    @(negedge clk);
    cfg_valid3 = 1'b0;
    c0 = cyc;
    check_eq("drop_ready_low0", cfg_ready3, 1'b0);
    wait_cyc(c0 + 2);
    check_eq("drop_ready_low2", cfg_ready3, 1'b0);
    wait_cyc(c0 + 3);
    check_eq("drop_ready_back", cfg_ready3, 1'b1);
    check_eq("drop_tone", tone3, 3'h0);

    // NCH=3, CW=8: full-range divide value 8'hFF.
    @(negedge clk);
    g = 0;
    while (!(slot3 == 2'd0 && cfg_ready3) && g < 64) begin
      @(negedge clk);
      g++;
    end
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd0; cfg_div3 = 8'hFF;
    @(negedge clk);
    cfg_valid3 = 1'b0;
    c0 = cyc;
    wait_cyc(c0 + 767);
    check_eq("max_pre", tone3[0], 1'b0);
    wait_cyc(c0 + 3 + int'(first_toggle(255, 3)));
    check_eq("max_tog1", tone3[0], 1'b1);
    check_eq("max_tog1_tick", tick3[0], 1'b1);
    wait_cyc(c0 + 1532);
    check_eq("max_hold", tone3[0], 1'b1);
    wait_cyc(c0 + 1533);
    check_eq("max_tog2", tone3[0], 1'b0);
    check_eq("max_tog2_tick", tick3[0], 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tone_div_sched.md
Name: tone_div_sched

Overview:
Time-multiplexed programmable frequency-divider bank for the synth voice path. A single shared increment/compare datapath serves NCH channels in round-robin slots. Each channel produces a square wave whose division ratio is set at runtime through a valid/ready config port. It replaces NCH fixed-parameter divider instances where voices need retunable pitch.

Parameters:
NCH, 4, number of channels; any value >= 1, power of 2 not required
CW, 16, width of the per-channel divide value and counter
SW, $clog2(NCH) (min 1), slot/channel index width (derived)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
cfg_valid  in  1  config request
cfg_ready  out  1  block can accept a config
cfg_ch  in  SW  target channel
cfg_div  in  CW  half-period in service visits; 0 = channel off
tone_out  out  NCH  per-channel square wave, registered
tick_out  out  NCH  one-clk pulse on every tone_out toggle, registered
slot  out  SW  channel serviced this cycle (debug/observability)

Behaviour:
- Reset is asynchronous, active-high:
  - slot=0, cfg_ready=1.
  - All div regs=0, cnt regs=0, tone_out=0, tick_out=0.
  - Any pending config is discarded.
- Slot pointer:
  - Advances every clk: 0,1,…,NCH-1, then wraps to 0.
  - Each channel is serviced exactly once per NCH clocks.
- Service of channel s when no config is being applied to s:
  - If div[s]==0: cnt[s]=0, tone_out[s]=0, no tick.
  - Else if cnt[s] >= div[s]-1: cnt[s]=0, tone_out[s] toggles, tick_out[s]=1 for the next cycle only. The >= also catches a counter that exceeds the divide value.
  - Else: cnt[s] increments by 1.
  - Non-serviced channels hold cnt and tone. Their tick_out is 0.
- Resulting tone period is 2*div*NCH clks; the first toggle after enable comes div*NCH clks after apply.
- Config handshake:
  - A transfer occurs when cfg_valid and cfg_ready are both 1 on a rising edge.
  - cfg_ch and cfg_div are captured into a single pending register, and cfg_ready drops to 0 the next cycle.
  - The pending config is applied on the first cycle with slot==pending_ch. This is never the acceptance cycle itself. Latency from acceptance to apply is 1..NCH clks.
  - On apply: div[ch]=pending_div, cnt[ch]=0, tone_out[ch]=0, no tick even if tone was 1. Normal servicing of that channel is skipped for that visit.
  - cfg_ready returns to 1 on the cycle after apply, giving one transfer per apply.
  - cfg_ch >= NCH (non-power-of-2 NCH) is accepted and dropped: it is never applied. cfg_ready returns to 1 after NCH clks.
- Inputs are ignored while cfg_ready=0; cfg_valid may stay high. cfg_valid must not be gated on cfg_ready.
- Reset mid-operation, including with a pending config, returns all state to reset values immediately.
- Width rules:
  - cnt is CW bits, and the compare is unsigned.
  - div-1 is computed only when div != 0, so there is no underflow.

Decomposition:
- Shared package holds:
  - slot-index width function (clog2 with min 1),
  - DIV_OFF constant (0),
  - localparam helpers for tone period = 2*div*NCH used by the bench.
- One sub-module is natural: tone_div_lane. It is the combinational next-state for one serviced channel (div, cnt, tone, apply, apply_div → cnt_nxt, tone_nxt, tick), instantiated once and shared via the slot mux.
- The top holds the slot counter, the register arrays, the pending register and the handshake.

Test Plan:
- Reset: rst=1 async mid-cycle → tone_out=0, tick_out=0, cfg_ready=1, slot=0 without waiting for clk. After release, slot cycles 0,1,2,3,0.
- Basic divide (NCH=4): write ch1 div=3 → tone_out[1] toggles every 12 clks. Period is 24 clks, and each edge coincides with a one-clk tick_out[1] pulse.
- Handshake latency: accept ch2 while slot=2 → applied at the next slot=2 (4 clks later). cfg_ready stays 0 during that time and is 1 the cycle after. A second cfg_valid held high is taken only then.
- Retune while running: ch0 div=5 with tone high, then write div=2 → tone_out[0] drops to 0 at apply with no tick. After that it toggles every 8 clks.
- Disable/boundaries:
  - div=0 → output held 0 and no ticks.
  - CW=16, div=16'hFFFF → first toggle after 65535*NCH clks, cnt wraps to 0 cleanly.
  - NCH=3 with cfg_ch=3 → never applied, cfg_ready recovers after 3 clks.
- Reset with pending config: accept ch3 div=7, assert rst before apply → after release div[3]=0 and tone_out[3] stays 0.
